// File: rtl/button_pkg.sv
// Shared types, default 100 MHz timing constants and width helpers for the
// N-channel button conditioner.
package button_pkg;

  typedef enum logic [1:0] {
    IDLE,
    DELAY,
    REPEAT
  } rep_state_t;

  localparam int DEF_CHANNELS      = 5;
  localparam int DEF_SYNC_STAGES   = 2;
  localparam int DEF_STABLE_CYCLES = 1_000_000;   // 10 ms
  localparam int DEF_REPEAT_DELAY  = 50_000_000;  // 500 ms
  localparam int DEF_REPEAT_PERIOD = 10_000_000;  // 100 ms

  // Ceiling log2, never below 1 so a counter always has at least one bit.
  function automatic int clog2_min1(input int value);
    int w;
    w = 0;
    while ((1 << w) < value) w++;
    return (w < 1) ? 1 : w;
  endfunction

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/button_channel.sv
// One button channel: synchroniser, stability-counter debouncer and
// typematic repeat FSM, all outputs registered.
module button_channel
  import button_pkg::*;
#(
  parameter int SYNC_STAGES   = DEF_SYNC_STAGES,
  parameter int STABLE_CYCLES = DEF_STABLE_CYCLES,
  parameter int REPEAT_DELAY  = DEF_REPEAT_DELAY,
  parameter int REPEAT_PERIOD = DEF_REPEAT_PERIOD,
  parameter int CNT_W         = 26
) (
  input  logic clock,
  input  logic reset,
  input  logic i_raw,
  input  logic i_repeat_en,
  output logic o_level,
  output logic o_press,
  output logic o_release,
  output logic o_pulse,
  output logic o_held
);

  logic [SYNC_STAGES-1:0] r_sync;
  logic                   r_level;
  logic                   r_press;
  logic                   r_release;
  logic                   r_pulse;
  logic                   r_held;
  logic [CNT_W-1:0]       r_dcnt;
  logic [CNT_W-1:0]       r_rcnt;
  logic [CNT_W-1:0]       w_rcnt_nxt;
  rep_state_t             r_state;
  rep_state_t             w_state_nxt;
  logic                   w_sync;
  logic                   w_expired;
  logic                   w_rise;
  logic                   w_fall;
  logic                   w_repeat;

  assign w_sync    = r_sync[SYNC_STAGES-1];
  // The differing level has persisted long enough on this very cycle.
  assign w_expired = (w_sync != r_level) && (r_dcnt == CNT_W'(STABLE_CYCLES - 1));
  assign w_rise    = w_expired && !r_level;
  assign w_fall    = w_expired && r_level;

  // NOTE: non-blocking assignments in every clocked block, so all flops
  // sample the pre-edge values regardless of statement order.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_sync    <= '0;
      r_level   <= 1'b0;
      r_dcnt    <= '0;
      r_press   <= 1'b0;
      r_release <= 1'b0;
    end else begin
      r_sync    <= {r_sync[SYNC_STAGES-2:0], i_raw};
      r_dcnt    <= (w_sync == r_level || w_expired) ? '0 : r_dcnt + CNT_W'(1);
      r_level   <= r_level ^ w_expired;
      r_press   <= w_rise;
      r_release <= w_fall;
    end
  end

  // NOTE: every always_comb output gets a default first; a path that leaves
  // one unassigned would infer a latch.
  always_comb begin
    w_state_nxt = r_state;
    w_rcnt_nxt  = r_rcnt;
    w_repeat    = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_rise && i_repeat_en) begin
          w_state_nxt = DELAY;
          w_rcnt_nxt  = '0;
        end
      end
      DELAY: begin
        if (w_fall || !i_repeat_en) begin
          w_state_nxt = IDLE;
          w_rcnt_nxt  = '0;
        end else if (r_rcnt == CNT_W'(REPEAT_DELAY - 1)) begin
          w_repeat    = 1'b1;
          w_state_nxt = REPEAT;
          w_rcnt_nxt  = '0;
        end else begin
          w_rcnt_nxt  = r_rcnt + CNT_W'(1);
        end
      end
      REPEAT: begin
        if (w_fall || !i_repeat_en) begin
          w_state_nxt = IDLE;
          w_rcnt_nxt  = '0;
        end else if (r_rcnt == CNT_W'(REPEAT_PERIOD - 1)) begin
          w_repeat    = 1'b1;
          w_rcnt_nxt  = '0;
        end else begin
          w_rcnt_nxt  = r_rcnt + CNT_W'(1);
        end
      end
      default: begin
        w_state_nxt = IDLE;
        w_rcnt_nxt  = '0;
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state <= IDLE;
      r_rcnt  <= '0;
      r_pulse <= 1'b0;
      r_held  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_rcnt  <= w_rcnt_nxt;
      r_pulse <= w_rise || w_repeat;
      r_held  <= (w_state_nxt == REPEAT);
    end
  end

  assign o_level   = r_level;
  assign o_press   = r_press;
  assign o_release = r_release;
  assign o_pulse   = r_pulse;
  assign o_held    = r_held;

endmodule

// File: rtl/button_conditioner_n.sv
// N independent button channels on the system clock; each channel is a
// self-contained button_channel instance.
module button_conditioner_n
  import button_pkg::*;
#(
  parameter int CHANNELS      = DEF_CHANNELS,
  parameter int SYNC_STAGES   = DEF_SYNC_STAGES,
  parameter int STABLE_CYCLES = DEF_STABLE_CYCLES,
  parameter int REPEAT_DELAY  = DEF_REPEAT_DELAY,
  parameter int REPEAT_PERIOD = DEF_REPEAT_PERIOD
) (
  input  logic                clock,
  input  logic                reset,
  input  logic [CHANNELS-1:0] io_in,
  input  logic [CHANNELS-1:0] repeat_en,
  output logic [CHANNELS-1:0] level,
  output logic [CHANNELS-1:0] press,
  output logic [CHANNELS-1:0] release_out,
  output logic [CHANNELS-1:0] pulse,
  output logic [CHANNELS-1:0] held
);

  localparam int CNT_W = clog2_min1(max3(STABLE_CYCLES, REPEAT_DELAY, REPEAT_PERIOD));

  for (genvar g = 0; g < CHANNELS; g++) begin : g_ch
    button_channel #(
      .SYNC_STAGES  (SYNC_STAGES),
      .STABLE_CYCLES(STABLE_CYCLES),
      .REPEAT_DELAY (REPEAT_DELAY),
      .REPEAT_PERIOD(REPEAT_PERIOD),
      .CNT_W        (CNT_W)
    ) u_channel (
      .clock      (clock),
      .reset      (reset),
      .i_raw      (io_in[g]),
      .i_repeat_en(repeat_en[g]),
      .o_level    (level[g]),
      .o_press    (press[g]),
      .o_release  (release_out[g]),
      .o_pulse    (pulse[g]),
      .o_held     (held[g])
    );
  end

endmodule

// File: tb/tb_button_conditioner_n.sv
// Bench for button_conditioner_n: directed scenarios with literal expectations
// plus a randomized phase, all compared every cycle against a history-window model.
module tb_button_conditioner_n;

  localparam int CH      = 5;
  localparam int SYNC    = 2;
  localparam int STABLE  = 4;
  localparam int RDELAY  = 10;
  localparam int RPERIOD = 3;
  localparam int NMAX    = 4096;

  logic          clock = 1'b0;
  logic          reset;
  logic [CH-1:0] io_in;
  logic [CH-1:0] repeat_en;
  logic [CH-1:0] level;
  logic [CH-1:0] press;
  logic [CH-1:0] release_out;
  logic [CH-1:0] pulse;
  logic [CH-1:0] held;

  always #5 clock = ~clock;

  button_conditioner_n #(
    .CHANNELS     (CH),
    .SYNC_STAGES  (SYNC),
    .STABLE_CYCLES(STABLE),
    .REPEAT_DELAY (RDELAY),
    .REPEAT_PERIOD(RPERIOD)
  ) dut (
    .clock      (clock),
    .reset      (reset),
    .io_in      (io_in),
    .repeat_en  (repeat_en),
    .level      (level),
    .press      (press),
    .release_out(release_out),
    .pulse      (pulse),
    .held       (held)
  );

  int cyc = 0;
  int n_vec = 0;
  int n_err = 0;

  // Inputs as sampled at each rising edge, indexed by edge number.
  logic [CH-1:0] raw_h [NMAX];
  logic          rst_h [NMAX];

  logic [CH-1:0] e_level, e_press, e_rel, e_pulse, e_held;
  bit            m_active [CH];
  int            m_p      [CH];
  int            tot_press[CH], tot_rel[CH], tot_pulse[CH], tot_held[CH];

  task automatic check(input string name, input int act, input int exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s at edge %0d: got %0h, want %0h", name, cyc - 1, act, exp);
    end
  endtask

  // Synchronised level visible after edge j: the raw value from SYNC-1 edges
  // earlier, or 0 if reset touched any of the edges in between.
  function automatic logic [CH-1:0] sync_after(input int j);
    if (j < SYNC - 1) return '0;
    for (int i = 0; i < SYNC; i++) if (rst_h[j-i]) return '0;
    return raw_h[j-SYNC+1];
  endfunction

  // Expected outputs right after edge k. A level flips once the STABLE
  // synchronised samples preceding the edge all disagree with it; repeat
  // strobes fall on press+RDELAY+n*RPERIOD while enabled and still held.
  task automatic model_step();
    int            k;
    logic          flip;
    logic [CH-1:0] s;
    k = cyc;
    if (k >= NMAX) begin
      $display("FAIL history overflow at edge %0d", k);
      $fatal(1, "bench history exhausted");
    end
    raw_h[k] = io_in;
    rst_h[k] = reset;
    e_press = '0; e_rel = '0; e_pulse = '0; e_held = '0;
    if (reset) begin
      e_level = '0;
      for (int c = 0; c < CH; c++) m_active[c] = 1'b0;
    end else begin
      for (int c = 0; c < CH; c++) begin
        flip = (k >= STABLE);
        for (int j = k - STABLE; j < k; j++) begin
          s = sync_after(j);
          if (s[c] == e_level[c]) flip = 1'b0;
        end
        e_press[c] = flip && !e_level[c];
        e_rel[c]   = flip && e_level[c];
        if (flip) e_level[c] = ~e_level[c];
        if (e_press[c]) begin
          m_active[c] = repeat_en[c];
          m_p[c]      = k;
        end else if (m_active[c] && (e_rel[c] || !repeat_en[c])) begin
          m_active[c] = 1'b0;
        end
        e_held[c]  = m_active[c] && (k - m_p[c] >= RDELAY);
        e_pulse[c] = e_press[c] ||
                     (e_held[c] && ((k - m_p[c] - RDELAY) % RPERIOD == 0));
      end
    end
    cyc++;
  endtask

  task automatic compare();
    check("level",   int'(level),       int'(e_level));
    check("press",   int'(press),       int'(e_press));
    check("release", int'(release_out), int'(e_rel));
    check("pulse",   int'(pulse),       int'(e_pulse));
    check("held",    int'(held),        int'(e_held));
    for (int c = 0; c < CH; c++) begin
      tot_press[c] += int'(press[c]);
      tot_rel[c]   += int'(release_out[c]);
      tot_pulse[c] += int'(pulse[c]);
      tot_held[c]  += int'(held[c]);
    end
  endtask

  // One clock: inputs were sampled at the last rising edge; check on the fall.
  task automatic tick();
    @(negedge clock);
    model_step();
    compare();
  endtask

  // Advance until edge `target` has been processed.
  task automatic run_to(input int target);
    while (cyc <= target) tick();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired at edge %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int e, t, r, p0, r0, h0;
    for (int c = 0; c < CH; c++) begin
      tot_press[c] = 0; tot_rel[c] = 0; tot_pulse[c] = 0; tot_held[c] = 0;
      m_p[c] = 0;
    end
    reset = 1'b1; io_in = '0; repeat_en = '0;
    run_to(2);
    check("rst_outputs", int'({level, press, release_out, pulse, held}), 0);
    reset = 1'b0;
    run_to(5);

    // Clean press and release on channel 0.
    e = cyc; io_in[0] = 1'b1;
    run_to(e + 4);  check("s1_press_early", int'(press[0]), 0);
    run_to(e + 5);  check("s1_press", int'({level[0], press[0], pulse[0]}), 3'b111);
    run_to(e + 6);  check("s1_press_once", int'({level[0], press[0]}), 2'b10);
    run_to(e + 19); io_in[0] = 1'b0;
    run_to(e + 24); check("s1_rel_early", int'(release_out[0]), 0);
    run_to(e + 25); check("s1_release", int'({level[0], release_out[0]}), 2'b01);
    run_to(e + 26); check("s1_rel_once", int'(release_out[0]), 0);

    // Bouncing channel 2: 2-cycle pulses never accepted, final rise is.
    p0 = tot_press[2]; r0 = tot_rel[2];
    for (int i = 0; i < 10; i++) begin
      io_in[2] = ~io_in[2];
      run_to(cyc + 1);
    end
    e = cyc; io_in[2] = 1'b1;
    run_to(e + 4);  check("s2_press_early", int'(press[2]), 0);
    run_to(e + 5);  check("s2_press", int'(press[2]), 1);
    run_to(e + 10);
    check("s2_press_count", tot_press[2] - p0, 1);
    check("s2_rel_count",   tot_rel[2] - r0, 0);

    // Auto-repeat on channel 0; release lands on a repeat expiry.
    repeat_en[0] = 1'b1;
    e = cyc; io_in[0] = 1'b1; t = e + 5;
    run_to(t);      check("s3_pulse_t", int'({press[0], pulse[0]}), 2'b11);
    run_to(t + 9);  check("s3_before_rep", int'({pulse[0], held[0]}), 2'b00);
    run_to(t + 10); check("s3_rep1", int'({pulse[0], held[0]}), 2'b11);
    run_to(t + 11); check("s3_gap", int'(pulse[0]), 0);
    run_to(t + 13); check("s3_rep2", int'(pulse[0]), 1);
    io_in[0] = 1'b0;
    run_to(t + 16); check("s3_rep3", int'(pulse[0]), 1);
    run_to(t + 19); check("s3_rel_wins", int'({pulse[0], release_out[0], held[0]}), 3'b010);
    run_to(t + 25);

    // Channel 1 held with repeat disabled: one pulse, never held.
    p0 = tot_pulse[1]; h0 = tot_held[1];
    io_in[1] = 1'b1;
    run_to(cyc + 49);
    check("s4_one_pulse", tot_pulse[1] - p0, 1);
    check("s4_no_held",   tot_held[1] - h0, 0);
    io_in[1] = 1'b0;
    run_to(cyc + 9);

    // Dropping repeat_en mid-REPEAT on channel 0.
    e = cyc; io_in[0] = 1'b1; t = e + 5;
    run_to(t + 11); check("s4_in_repeat", int'(held[0]), 1);
    repeat_en[0] = 1'b0;
    run_to(t + 12); check("s4_held_drop", int'(held[0]), 0);
    run_to(t + 13); check("s4_no_rep", int'(pulse[0]), 0);
    repeat_en[0] = 1'b1;
    run_to(t + 30); check("s4_stays_idle", int'(held[0]), 0);
    io_in[0] = 1'b0;
    run_to(cyc + 9);

    // Simultaneous presses on channels 1 and 3.
    e = cyc; io_in[1] = 1'b1; io_in[3] = 1'b1;
    run_to(e + 4);  check("s5_early", int'(press), 0);
    run_to(e + 5);  check("s5_press", int'(press), 5'b01010);
    run_to(e + 6);  check("s5_once", int'(press), 0);
    io_in[1] = 1'b0; io_in[3] = 1'b0;
    run_to(cyc + 9);

    // Reset while channel 0 is repeating and still held (channel 2 also held).
    e = cyc; io_in[0] = 1'b1; t = e + 5;
    run_to(t + 11); check("s6_in_repeat", int'(held[0]), 1);
    reset = 1'b1;
    for (int i = 0; i < 3; i++) begin
      run_to(cyc);
      check("s6_rst_zero", int'({level, press, release_out, pulse, held}), 0);
    end
    r = cyc - 1;
    reset = 1'b0;
    run_to(r + 5);  check("s6_press_early", int'(press), 0);
    run_to(r + 6);  check("s6_press", int'(press), 5'b00101);
    run_to(r + 20);

    // Randomized phase: short and long runs, repeat_en flips, rare resets.
    for (int i = 0; i < 1500; i++) begin
      for (int c = 0; c < CH; c++) begin
        if ($urandom_range(0, 4) == 0) io_in[c] = ~io_in[c];
        if ($urandom_range(0, 49) == 0) repeat_en[c] = ~repeat_en[c];
      end
      reset = ($urandom_range(0, 399) == 0);
      run_to(cyc);
    end
    reset = 1'b0;
    run_to(cyc + 5);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
